// File: rtl/vproc_pkg.sv
// Shared types for the vector result packing slice.
//   cfg_vsew   : element width encoding (8/16/32 bit)
//   pack_flags : per-chunk store info travelling with each result chunk
//   pack_state : result packer output FSM state
package vproc_pkg;

    typedef enum logic [1:0] {
        VSEW_8       = 2'b00,
        VSEW_16      = 2'b01,
        VSEW_32      = 2'b10,
        VSEW_INVALID = 2'b11
    } cfg_vsew;

    typedef struct packed {
        logic       shift;     // chunk carries data to be committed
        logic       elemwise;  // only the lowest element is committed
        logic       narrow;    // double-width elements are halved
        logic       saturate;  // clamp instead of truncate when narrowing
        logic       sig;       // signed clamp bounds
        logic [2:0] mul_idx;   // register offset inside the register group
    } pack_flags;

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } pack_state;

endpackage

// File: rtl/vproc_pack_narrow.sv
// Combinational narrowing of a result chunk: each 2*w-bit element becomes a
// w-bit element (w = 8 << eew), optionally saturated.
//   eew_i      : destination element width
//   saturate_i : clamp out-of-range elements instead of truncating
//   sig_i      : signed (1) or unsigned (0) clamp bounds
//   data_i     : OP_W-bit chunk of double-width elements
//   data_o     : OP_W/2-bit packed narrowed elements
//   sat_o      : at least one element was clamped
module vproc_pack_narrow
    import vproc_pkg::*;
#(
    parameter int unsigned OP_W = 32
) (
    input  cfg_vsew             eew_i,
    input  logic                saturate_i,
    input  logic                sig_i,
    input  logic [OP_W-1:0]     data_i,
    output logic [OP_W/2-1:0]   data_o,
    output logic                sat_o
);

    logic [OP_W/2-1:0] res_w [3];
    logic [2:0]        sat_w;

    for (genvar k = 0; k < 3; k++) begin : g_w
        localparam int unsigned W = 8 << k;
        localparam int unsigned N = OP_W / (2 * W);

        if (N == 0) begin : g_none
            assign res_w[k] = '0;
            assign sat_w[k] = 1'b0;
        end else begin : g_elems
            logic [OP_W/2-1:0] res;
            logic [N-1:0]      ovf;

            for (genvar j = 0; j < N; j++) begin : g_e
                logic [2*W-1:0] e;
                logic           fits_s;
                logic           fits_u;

                assign e = data_i[j*2*W +: 2*W];
                // Signed value fits in w bits when the top w+1 bits are all
                // copies of the sign; unsigned when the top w bits are zero.
                assign fits_s = (&e[2*W-1:W-1]) | ~(|e[2*W-1:W-1]);
                assign fits_u = ~(|e[2*W-1:W]);
                assign ovf[j] = saturate_i & ~(sig_i ? fits_s : fits_u);
                assign res[j*W +: W] = !ovf[j] ? e[W-1:0] :
                                       !sig_i  ? {W{1'b1}} :
                                       e[2*W-1] ? {1'b1, {(W-1){1'b0}}} :
                                                  {1'b0, {(W-1){1'b1}}};
            end

            assign res_w[k] = res;
            assign sat_w[k] = |ovf;
        end
    end

    always_comb begin
        data_o = res_w[0];
        sat_o  = sat_w[0];
        case (eew_i)
            VSEW_16: begin
                data_o = res_w[1];
                sat_o  = sat_w[1];
            end
            VSEW_32: begin
                data_o = res_w[2];
                sat_o  = sat_w[2];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/vproc_result_pack.sv
// Packs result chunks into full vector register writes.
//   clk_i, sync_rst_i        : clock, synchronous active-high reset
//   in_valid_i / in_ready_o  : result chunk handshake
//   in_flags_i, in_eew_i     : per-chunk store info, element width
//   in_vaddr_i, in_last_i    : destination base vreg, last chunk (flush)
//   in_res_i, in_mask_i      : chunk data, per-byte write mask
//   out_valid_o / out_ready_i: vreg write handshake
//   out_addr_o, out_data_o, out_be_o : vreg write address, data, byte enables
//   sat_o                    : pulse when a committed chunk saturated
module vproc_result_pack
    import vproc_pkg::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned OP_W   = 32
) (
    input  logic                clk_i,
    input  logic                sync_rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  pack_flags           in_flags_i,
    input  cfg_vsew             in_eew_i,
    input  logic [4:0]          in_vaddr_i,
    input  logic                in_last_i,
    input  logic [OP_W-1:0]     in_res_i,
    input  logic [OP_W/8-1:0]   in_mask_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [4:0]          out_addr_o,
    output logic [VREG_W-1:0]   out_data_o,
    output logic [VREG_W/8-1:0] out_be_o,
    output logic                sat_o
);

    localparam int unsigned VREG_B = VREG_W / 8;
    localparam int unsigned OP_B   = OP_W / 8;
    localparam int unsigned PW     = $clog2(VREG_B) + 1;

    pack_state         state_q;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [VREG_W-1:0] buf_q, buf_d;
    logic [VREG_B-1:0] be_q, be_d;
    logic [4:0]        addr_q, addr_d;
    logic [VREG_W-1:0] out_data_q;
    logic [VREG_B-1:0] out_be_q;
    logic [4:0]        out_addr_q;
    logic              sat_q;

    logic [OP_W/2-1:0] narrow_res;
    logic              narrow_sat;
    logic              accept, commit, flush;
    logic [OP_W-1:0]   src;
    logic [PW-1:0]     nbytes;
    logic [OP_B-1:0]   byte_sel;
    logic [VREG_B-1:0] wr_sel, wr_be;
    logic [VREG_W-1:0] wr_data;

    vproc_pack_narrow #(
        .OP_W (OP_W)
    ) u_narrow (
        .eew_i      (in_eew_i),
        .saturate_i (in_flags_i.saturate),
        .sig_i      (in_flags_i.sig),
        .data_i     (in_res_i),
        .data_o     (narrow_res),
        .sat_o      (narrow_sat)
    );

    assign out_valid_o = (state_q == EMIT);
    assign in_ready_o  = !out_valid_o || out_ready_i;
    assign out_data_o  = out_data_q;
    assign out_be_o    = out_be_q;
    assign out_addr_o  = out_addr_q;
    assign sat_o       = sat_q;

    always_comb begin
        accept = in_valid_i && in_ready_o;
        commit = accept && in_flags_i.shift;
        src    = in_flags_i.narrow ? OP_W'(narrow_res) : in_res_i;

        if (in_flags_i.elemwise) begin
            nbytes = PW'(1) << in_eew_i;
        end else if (in_flags_i.narrow) begin
            nbytes = PW'(OP_B / 2);
        end else begin
            nbytes = PW'(OP_B);
        end

        for (int unsigned k = 0; k < OP_B; k++) begin
            byte_sel[k] = (PW'(k) < nbytes);
        end

        // Place the committed bytes at the byte pointer inside the vreg.
        wr_sel  = VREG_B'(byte_sel) << ptr_q;
        wr_be   = VREG_B'(byte_sel & in_mask_i) << ptr_q;
        wr_data = VREG_W'(src) << {ptr_q, 3'b000};

        buf_d  = buf_q;
        be_d   = be_q;
        ptr_d  = ptr_q;
        addr_d = addr_q;
        if (commit) begin
            for (int unsigned b = 0; b < VREG_B; b++) begin
                if (wr_sel[b]) begin
                    buf_d[b*8 +: 8] = wr_data[b*8 +: 8];
                    be_d[b]         = wr_be[b];
                end
            end
            ptr_d = ptr_q + nbytes;
            if (ptr_q == '0) begin
                addr_d = in_vaddr_i + 5'(in_flags_i.mul_idx);
            end
        end

        // Flush on the merged view so a filling chunk is written next cycle.
        flush = accept && ((ptr_d >= PW'(VREG_B)) || (in_last_i && ptr_d != '0));
    end

    always_ff @(posedge clk_i) begin
        if (sync_rst_i) begin
            state_q    <= FILL;
            ptr_q      <= '0;
            be_q       <= '0;
            addr_q     <= '0;
            out_be_q   <= '0;
            out_addr_q <= '0;
            sat_q      <= 1'b0;
        end else begin
            sat_q <= commit && in_flags_i.narrow && narrow_sat;
            if (flush) begin
                out_data_q <= buf_d;
                out_be_q   <= be_d;
                out_addr_q <= addr_d;
                state_q    <= EMIT;
                ptr_q      <= '0;
                be_q       <= '0;
            end else begin
                buf_q  <= buf_d;
                be_q   <= be_d;
                ptr_q  <= ptr_d;
                addr_q <= addr_d;
                if (state_q == EMIT && out_ready_i) begin
                    state_q <= FILL;
                end
            end
        end
    end

endmodule

// File: tb/tb_vproc_result_pack.sv
module tb_vproc_result_pack;
    import vproc_pkg::*;

    logic          clk_i = 1'b0;
    logic          sync_rst_i;
    logic          in_valid_i;
    logic          in_ready_o;
    pack_flags     in_flags_i;
    cfg_vsew       in_eew_i;
    logic [4:0]    in_vaddr_i;
    logic          in_last_i;
    logic [31:0]   in_res_i;
    logic [3:0]    in_mask_i;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [4:0]    out_addr_o;
    logic [127:0]  out_data_o;
    logic [15:0]   out_be_o;
    logic          sat_o;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int c0;

    vproc_result_pack #(
        .VREG_W (128),
        .OP_W   (32)
    ) dut (
        .clk_i       (clk_i),
        .sync_rst_i  (sync_rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_flags_i  (in_flags_i),
        .in_eew_i    (in_eew_i),
        .in_vaddr_i  (in_vaddr_i),
        .in_last_i   (in_last_i),
        .in_res_i    (in_res_i),
        .in_mask_i   (in_mask_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_addr_o  (out_addr_o),
        .out_data_o  (out_data_o),
        .out_be_o    (out_be_o),
        .sat_o       (sat_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (!sync_rst_i && out_valid_o && out_ready_i) wr_cnt <= wr_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic pack_flags mk(input logic sh, input logic ew, input logic nr,
                                     input logic st, input logic sg, input logic [2:0] mi);
        pack_flags f;
        f.shift = sh; f.elemwise = ew; f.narrow = nr;
        f.saturate = st; f.sig = sg; f.mul_idx = mi;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] res, input logic [3:0] mask, input logic last);
        logic rdy;
        int   n;
        in_res_i = res; in_mask_i = mask; in_last_i = last; in_valid_i = 1'b1;
        n = 0;
        forever begin
            rdy = in_ready_o;
            @(posedge clk_i); #1;
            if (rdy) break;
            n++;
            if (n > 50) begin
                checks++; errors++;
                $display("FAIL send_timeout: observed in_ready_o=0 expected 1 within 50 cycles");
                break;
            end
        end
        in_valid_i = 1'b0; in_last_i = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [4:0] addr,
                                input logic [127:0] data, input logic [127:0] dmask,
                                input logic [15:0] be);
        chk({tag, "_valid"}, 128'(out_valid_o), 128'(1));
        chk({tag, "_addr"},  128'(out_addr_o), 128'(addr));
        chk({tag, "_data"},  out_data_o & dmask, data);
        chk({tag, "_be"},    128'(out_be_o), 128'(be));
    endtask

    initial begin
        sync_rst_i = 1'b1; in_valid_i = 1'b0; in_flags_i = mk(0, 0, 0, 0, 0, 0);
        in_eew_i = VSEW_32; in_vaddr_i = 5'd0; in_last_i = 1'b0;
        in_res_i = '0; in_mask_i = 4'hF; out_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_valid", 128'(out_valid_o), 128'(0));
        chk("rst_be",    128'(out_be_o), 128'(0));
        chk("rst_addr",  128'(out_addr_o), 128'(0));
        chk("rst_sat",   128'(sat_o), 128'(0));
        chk("rst_ready", 128'(in_ready_o), 128'(1));
        sync_rst_i = 1'b0;

        // Four full-width chunks fill one vreg
        in_flags_i = mk(1, 0, 0, 0, 0, 0); in_eew_i = VSEW_32;
        send(32'h11111111, 4'hF, 0);
        send(32'h22222222, 4'hF, 0);
        send(32'h33333333, 4'hF, 0);
        chk("fill_partial_valid", 128'(out_valid_o), 128'(0));
        send(32'h44444444, 4'hF, 0);
        expect_write("fill", 5'd0, 128'h44444444_33333333_22222222_11111111, '1, 16'hFFFF);

        // Signed saturating narrow 16->8
        in_flags_i = mk(1, 0, 1, 1, 1, 0); in_eew_i = VSEW_8;
        send(32'h0080_FF7F, 4'hF, 1);
        chk("nsig_sat", 128'(sat_o), 128'(1));
        expect_write("nsig", 5'd0, 128'h7F80, 128'hFFFF, 16'h0003);

        // Unsigned saturating narrow 16->8
        in_flags_i = mk(1, 0, 1, 1, 0, 0);
        send(32'h0123_00FF, 4'hF, 1);
        chk("nuns_sat", 128'(sat_o), 128'(1));
        expect_write("nuns", 5'd0, 128'hFFFF, 128'hFFFF, 16'h0003);

        // Truncating narrow 32->16, two chunks advance ptr by 2 bytes each
        in_flags_i = mk(1, 0, 1, 0, 1, 0); in_eew_i = VSEW_16;
        send(32'hDEADBEEF, 4'hF, 0);
        chk("ntrunc_sat0", 128'(sat_o), 128'(0));
        send(32'h12345678, 4'hF, 1);
        chk("ntrunc_sat1", 128'(sat_o), 128'(0));
        expect_write("ntrunc", 5'd0, 128'h5678BEEF, 128'hFFFFFFFF, 16'h000F);

        // Address offset, partial flush by last
        in_flags_i = mk(1, 0, 0, 0, 0, 3'd2); in_eew_i = VSEW_32; in_vaddr_i = 5'd8;
        send(32'hA1A1A1A1, 4'hF, 0);
        send(32'hA2A2A2A2, 4'hF, 1);
        expect_write("addr", 5'd10, 128'hA2A2A2A2_A1A1A1A1, {64'h0, {64{1'b1}}}, 16'h00FF);

        in_vaddr_i = 5'd31;
        send(32'hC0FFEE00, 4'hF, 1);
        expect_write("addr_wrap", 5'd1, 128'hC0FFEE00, 128'hFFFFFFFF, 16'h000F);

        // Byte mask 0101 on every chunk
        in_flags_i = mk(1, 0, 0, 0, 0, 0); in_vaddr_i = 5'd3;
        send(32'h11111111, 4'b0101, 0);
        send(32'h22222222, 4'b0101, 0);
        send(32'h33333333, 4'b0101, 0);
        send(32'h44444444, 4'b0101, 0);
        expect_write("mask", 5'd3, 128'h00440044_00330033_00220022_00110011,
                     128'h00FF00FF_00FF00FF_00FF00FF_00FF00FF, 16'h5555);

        // Element-wise byte commits
        in_flags_i = mk(1, 1, 0, 0, 0, 0); in_eew_i = VSEW_8; in_vaddr_i = 5'd4;
        send(32'hAAAAAA11, 4'hF, 0);
        send(32'hBBBBBB22, 4'hF, 0);
        send(32'hCCCCCC33, 4'hF, 0);
        send(32'hDDDDDD44, 4'hF, 1);
        expect_write("elem", 5'd4, 128'h44332211, 128'hFFFFFFFF, 16'h000F);

        // shift=0 chunks are dropped; last on an empty buffer emits nothing
        @(posedge clk_i); #1;
        c0 = wr_cnt;
        in_flags_i = mk(0, 0, 0, 0, 0, 0); in_eew_i = VSEW_32; in_vaddr_i = 5'd0;
        send(32'hDEADDEAD, 4'hF, 1);
        chk("drop_empty_valid", 128'(out_valid_o), 128'(0));
        @(posedge clk_i); #1;
        chk("drop_empty_cnt", 128'(wr_cnt), 128'(c0));
        in_flags_i = mk(1, 0, 0, 0, 0, 0);
        send(32'h01010101, 4'hF, 0);
        in_flags_i = mk(0, 0, 0, 0, 0, 0);
        send(32'hBADBAD00, 4'hF, 0);
        in_flags_i = mk(1, 0, 0, 0, 0, 0);
        send(32'h02020202, 4'hF, 0);
        send(32'h03030303, 4'hF, 0);
        send(32'h04040404, 4'hF, 0);
        expect_write("drop_mid", 5'd0, 128'h04040404_03030303_02020202_01010101, '1, 16'hFFFF);
        send(32'h77777777, 4'hF, 0);
        in_flags_i = mk(0, 0, 0, 0, 0, 0);
        send(32'hBADBAD01, 4'hF, 1);
        expect_write("drop_last", 5'd0, 128'h77777777, 128'hFFFFFFFF, 16'h000F);

        // Backpressure: hold EMIT for 5 cycles, then release
        in_flags_i = mk(1, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        out_ready_i = 1'b0;
        send(32'hA0000001, 4'hF, 0);
        send(32'hA0000002, 4'hF, 0);
        send(32'hA0000003, 4'hF, 0);
        send(32'hA0000004, 4'hF, 0);
        expect_write("bp_a", 5'd0, 128'hA0000004_A0000003_A0000002_A0000001, '1, 16'hFFFF);
        in_res_i = 32'hB0000001; in_mask_i = 4'hF; in_last_i = 1'b0; in_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            chk($sformatf("bp_ready_%0d", i), 128'(in_ready_o), 128'(0));
            chk($sformatf("bp_hold_%0d", i), out_data_o,
                128'hA0000004_A0000003_A0000002_A0000001);
            chk($sformatf("bp_valid_%0d", i), 128'(out_valid_o), 128'(1));
        end
        out_ready_i = 1'b1;
        @(posedge clk_i); #1;
        in_valid_i = 1'b0;
        chk("bp_release_valid", 128'(out_valid_o), 128'(0));
        send(32'hB0000002, 4'hF, 0);
        send(32'hB0000003, 4'hF, 0);
        send(32'hB0000004, 4'hF, 0);
        expect_write("bp_b", 5'd0, 128'hB0000004_B0000003_B0000002_B0000001, '1, 16'hFFFF);

        // Reset in the middle of a partially filled buffer
        @(posedge clk_i); #1;
        c0 = wr_cnt;
        send(32'hE0000001, 4'hF, 0);
        send(32'hE0000002, 4'hF, 0);
        sync_rst_i = 1'b1;
        @(posedge clk_i); #1;
        sync_rst_i = 1'b0;
        chk("mrst_valid", 128'(out_valid_o), 128'(0));
        chk("mrst_be", 128'(out_be_o), 128'(0));
        send(32'h55555555, 4'hF, 0);
        send(32'h66666666, 4'hF, 0);
        chk("mrst_half_valid", 128'(out_valid_o), 128'(0));
        send(32'h77777777, 4'hF, 0);
        send(32'h88888888, 4'hF, 0);
        expect_write("mrst", 5'd0, 128'h88888888_77777777_66666666_55555555, '1, 16'hFFFF);
        chk("mrst_cnt_before", 128'(wr_cnt), 128'(c0));
        @(posedge clk_i); #1;
        chk("mrst_cnt_after", 128'(wr_cnt), 128'(c0 + 1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
